// File: rtl/bch_ecc_packet_encoder.sv
// Multi-lane BCH(64,56)-family ECC encoder for HDMI data-island packets.
// Optional receive-side checking is enabled with `define BCH_ECC_SYNDROME_EN.
module bch_ecc_packet_encoder #(
  parameter int LANES         = 4,
  parameter int BITS_PER_LANE = 2,
  parameter int DATA_CLOCKS   = 28
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [LANES*BITS_PER_LANE-1:0] data_in,
  output logic [LANES*BITS_PER_LANE-1:0] data_out,
  output logic                           out_valid,
  output logic                           out_parity,
  output logic                           out_last,
  output logic                           busy
`ifdef BCH_ECC_SYNDROME_EN
  ,
  output logic [LANES-1:0]               syndrome_error
`endif
);

  localparam int W             = LANES * BITS_PER_LANE;
  localparam int PARITY_CLOCKS = 8 / BITS_PER_LANE;
  localparam int TOTAL         = DATA_CLOCKS + PARITY_CLOCKS;
  localparam int CW            = (TOTAL > 2) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t                r_state, w_stateNext;
  logic [CW-1:0]         r_count, w_countNext;
  logic [LANES-1:0][7:0] r_ecc, w_eccNext;
  logic [W-1:0]          r_dataOut, w_dataNext;
  logic                  r_valid, w_validNext;
  logic                  r_parity, w_parityNext;
  logic                  r_last, w_lastNext;
  logic                  r_busy;
`ifdef BCH_ECC_SYNDROME_EN
  logic [LANES-1:0]      r_syndrome, w_synNext;
`endif

  // One clock worth of LFSR steps for a single lane, bit 0 first.
  function automatic logic [7:0] lfsrStep(input logic [7:0] seed,
                                          input logic [BITS_PER_LANE-1:0] bits);
    logic [7:0] ecc;
    logic       fb;
    ecc = seed;
    for (int j = 0; j < BITS_PER_LANE; j++) begin
      fb  = bits[j] ^ ecc[0];
      ecc = (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
    end
    return ecc;
  endfunction

  always_comb begin
    w_stateNext  = r_state;
    w_countNext  = r_count;
    w_eccNext    = r_ecc;
    w_dataNext   = '0;
    w_validNext  = 1'b0;
    w_parityNext = 1'b0;
    w_lastNext   = 1'b0;
`ifdef BCH_ECC_SYNDROME_EN
    w_synNext    = '0;
`endif
    // A start strobe restarts from a zero seed regardless of the current state.
    if (start) begin
      w_stateNext = (DATA_CLOCKS == 1) ? PARITY : DATA;
      w_countNext = CW'(1);
      w_dataNext  = data_in;
      w_validNext = 1'b1;
      for (int k = 0; k < LANES; k++)
        w_eccNext[k] = lfsrStep(8'h00, data_in[k*BITS_PER_LANE +: BITS_PER_LANE]);
    end else begin
      case (r_state)
        DATA: begin
          w_dataNext  = data_in;
          w_validNext = 1'b1;
          w_countNext = r_count + CW'(1);
          for (int k = 0; k < LANES; k++)
            w_eccNext[k] = lfsrStep(r_ecc[k], data_in[k*BITS_PER_LANE +: BITS_PER_LANE]);
          if (r_count == CW'(DATA_CLOCKS - 1))
            w_stateNext = PARITY;
        end
        PARITY: begin
          w_validNext  = 1'b1;
          w_parityNext = 1'b1;
          for (int k = 0; k < LANES; k++) begin
            w_dataNext[k*BITS_PER_LANE +: BITS_PER_LANE] = r_ecc[k][BITS_PER_LANE-1:0];
`ifdef BCH_ECC_SYNDROME_EN
            // Feeding the received parity leaves a zero remainder for a clean codeword.
            w_eccNext[k] = lfsrStep(r_ecc[k], data_in[k*BITS_PER_LANE +: BITS_PER_LANE]);
`else
            w_eccNext[k] = r_ecc[k] >> BITS_PER_LANE;
`endif
          end
          if (r_count == CW'(TOTAL - 1)) begin
            w_lastNext  = 1'b1;
            w_stateNext = IDLE;
            w_countNext = '0;
`ifdef BCH_ECC_SYNDROME_EN
            for (int k = 0; k < LANES; k++)
              w_synNext[k] = |w_eccNext[k];
`endif
          end else begin
            w_countNext = r_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_ecc      <= '0;
      r_dataOut  <= '0;
      r_valid    <= 1'b0;
      r_parity   <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef BCH_ECC_SYNDROME_EN
      r_syndrome <= '0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_ecc      <= w_eccNext;
      r_dataOut  <= w_dataNext;
      r_valid    <= w_validNext;
      r_parity   <= w_parityNext;
      r_last     <= w_lastNext;
      r_busy     <= w_validNext;
`ifdef BCH_ECC_SYNDROME_EN
      r_syndrome <= w_synNext;
`endif
    end
  end

  assign data_out   = r_dataOut;
  assign out_valid  = r_valid;
  assign out_parity = r_parity;
  assign out_last   = r_last;
  assign busy       = r_busy;
`ifdef BCH_ECC_SYNDROME_EN
  assign syndrome_error = r_syndrome;
`endif

endmodule

// File: tb/tb_bch_ecc_packet_encoder.sv
// Self-checking bench for bch_ecc_packet_encoder: directed table, random packets,
// abort/back-to-back/reset sequences and a 1-lane header instance.
module tb_bch_ecc_packet_encoder;

  localparam int LANES = 4;
  localparam int BPL   = 2;
  localparam int DC    = 28;
  localparam int PC    = 8 / BPL;
  localparam int TOTAL = DC + PC;
  localparam int W     = LANES * BPL;
  localparam int HDC   = 24;
  localparam int HTOT  = HDC + 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic [W-1:0] dataOut;
  logic         outValid, outParity, outLast, busy;

  logic         hStart = 1'b0;
  logic [0:0]   hDataIn = '0;
  logic [0:0]   hDataOut;
  logic         hValid, hParity, hLast, hBusy;
`ifdef BCH_ECC_SYNDROME_EN
  logic [LANES-1:0] synErr;
  logic [0:0]       hSynErr;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pkt   [DC];
  logic [7:0]   par   [LANES];
  logic [7:0]   rxPar [LANES];

  typedef struct {
    string                  name;
    logic [LANES-1:0][55:0] bits;
    logic [LANES-1:0][7:0]  expPar;
  } vecT;
  vecT vectors [3];

  bch_ecc_packet_encoder #(.LANES(LANES), .BITS_PER_LANE(BPL), .DATA_CLOCKS(DC)) dut (
    .clock(clock), .reset(reset), .start(start), .data_in(dataIn),
    .data_out(dataOut), .out_valid(outValid), .out_parity(outParity),
    .out_last(outLast), .busy(busy)
`ifdef BCH_ECC_SYNDROME_EN
    , .syndrome_error(synErr)
`endif
  );

  bch_ecc_packet_encoder #(.LANES(1), .BITS_PER_LANE(1), .DATA_CLOCKS(HDC)) hdr (
    .clock(clock), .reset(reset), .start(hStart), .data_in(hDataIn),
    .data_out(hDataOut), .out_valid(hValid), .out_parity(hParity),
    .out_last(hLast), .busy(hBusy)
`ifdef BCH_ECC_SYNDROME_EN
    , .syndrome_error(hSynErr)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the per-bit division rule applied over the whole flat bit stream of a lane.
  function automatic logic [7:0] specStep(input logic [7:0] ecc, input logic d);
    logic fb;
    fb = d ^ ecc[0];
    return (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
  endfunction

  task automatic computeParity();
    logic [7:0] ecc;
    for (int k = 0; k < LANES; k++) begin
      ecc = 8'h00;
      for (int t = 0; t < DC; t++)
        for (int j = 0; j < BPL; j++)
          ecc = specStep(ecc, pkt[t][k*BPL + j]);
      par[k] = ecc;
    end
  endtask

  task automatic preparePacket();
    computeParity();
    rxPar = par;
  endtask

  task automatic randomPacket();
    for (int t = 0; t < DC; t++) pkt[t] = W'($urandom);
  endtask

  function automatic logic [W-1:0] parityWord(input logic [7:0] p [LANES], input int t);
    logic [W-1:0] w;
    logic [7:0]   s;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      s = p[k] >> (BPL * (t - DC));
      w[k*BPL +: BPL] = s[BPL-1:0];
    end
    return w;
  endfunction

  function automatic logic [W-1:0] expectedWord(input int t);
    if (t < DC) return pkt[t];
    return parityWord(par, t);
  endfunction

  function automatic logic [LANES-1:0] expectedSyndrome();
    logic [LANES-1:0] syn;
    logic [7:0]       ecc;
    for (int k = 0; k < LANES; k++) begin
      ecc = 8'h00;
      for (int t = 0; t < DC; t++)
        for (int j = 0; j < BPL; j++)
          ecc = specStep(ecc, pkt[t][k*BPL + j]);
      for (int b = 0; b < 8; b++)
        ecc = specStep(ecc, rxPar[k][b]);
      syn[k] = (ecc != 8'h00);
    end
    return syn;
  endfunction

  task automatic applyStimulus(input logic st, input logic [W-1:0] d);
    start  = st;
    dataIn = d;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic v, input logic p, input logic l,
                             input logic b, input logic [W-1:0] d);
    checkVal({tag, " valid"},  64'(outValid),  64'(v));
    checkVal({tag, " parity"}, 64'(outParity), 64'(p));
    checkVal({tag, " last"},   64'(outLast),   64'(l));
    checkVal({tag, " busy"},   64'(busy),      64'(b));
    checkVal({tag, " data"},   64'(dataOut),   64'(d));
  endtask

  // Drives the first 'edges' clocks of the current packet and checks each output word.
  task automatic streamPacket(input string tag, input int edges);
    logic [W-1:0] d;
    string        nm;
    for (int t = 0; t < edges; t++) begin
      if (t < DC) d = pkt[t];
`ifdef BCH_ECC_SYNDROME_EN
      else d = parityWord(rxPar, t);
`else
      else d = W'($urandom);
`endif
      applyStimulus(t == 0, d);
      nm = $sformatf("%s w%0d", tag, t);
      checkOutput(nm, 1'b1, t >= DC, t == TOTAL - 1, 1'b1, expectedWord(t));
`ifdef BCH_ECC_SYNDROME_EN
      checkVal({nm, " syndrome"}, 64'(synErr),
               64'((t == TOTAL - 1) ? expectedSyndrome() : '0));
`endif
    end
  endtask

  task automatic idleCheck(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, W'($urandom));
      checkOutput(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifdef BCH_ECC_SYNDROME_EN
      checkVal({tag, " syndrome"}, 64'(synErr), 64'(0));
`endif
    end
  endtask

  initial begin
    vectors[0].name = "allZero";
    vectors[0].bits = '0;
    vectors[0].expPar = '0;
    vectors[1].name = "lane0Bit55";
    vectors[1].bits = '0;
    vectors[1].bits[0][55] = 1'b1;
    vectors[1].expPar = '0;
    vectors[1].expPar[0] = 8'h83;
    vectors[2].name = "lane2Lane3";
    vectors[2].bits = '0;
    vectors[2].bits[2][54] = 1'b1;
    vectors[2].bits[3][54] = 1'b1;
    vectors[2].bits[3][55] = 1'b1;
    vectors[2].expPar = '0;
    vectors[2].expPar[2] = 8'hC2;
    vectors[2].expPar[3] = 8'h41;

    // Reset held with start asserted: reset must win.
    reset  = 1'b1;
    hStart = 1'b1;
    applyStimulus(1'b1, W'($urandom));
    applyStimulus(1'b1, W'($urandom));
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkVal("hdr reset valid", 64'(hValid), 64'(0));
    reset  = 1'b0;
    hStart = 1'b0;
    idleCheck("idle", 2);

    for (int v = 0; v < 3; v++) begin
      for (int t = 0; t < DC; t++)
        for (int k = 0; k < LANES; k++)
          pkt[t][k*BPL +: BPL] = vectors[v].bits[k][t*BPL +: BPL];
      for (int k = 0; k < LANES; k++) par[k] = vectors[v].expPar[k];
      rxPar = par;
      streamPacket(vectors[v].name, TOTAL);
      idleCheck({vectors[v].name, " tail"}, 1);
    end

    for (int i = 0; i < 6; i++) begin
      randomPacket();
      preparePacket();
      streamPacket($sformatf("rand%0d", i), TOTAL);
      if (i % 2 == 1) idleCheck("rand gap", 1);
    end

    randomPacket(); preparePacket(); streamPacket("abortData", 10);
    randomPacket(); preparePacket(); streamPacket("restart", TOTAL);
    randomPacket(); preparePacket(); streamPacket("backToBack", TOTAL);
    randomPacket(); preparePacket(); streamPacket("abortParity", DC + 2);
    randomPacket(); preparePacket(); streamPacket("restartP", TOTAL);
    idleCheck("after restarts", 2);

    randomPacket(); preparePacket(); streamPacket("preReset", DC + 2);
    reset = 1'b1;
    applyStimulus(1'b1, W'($urandom));
    checkOutput("midParityReset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    idleCheck("postReset", 2);
    randomPacket(); preparePacket(); streamPacket("recover", TOTAL);
    idleCheck("recover tail", 1);

`ifdef BCH_ECC_SYNDROME_EN
    randomPacket();
    computeParity();
    rxPar = par;
    pkt[3][1] = ~pkt[3][1];
    computeParity();
    checkVal("flip syndrome model", 64'(expectedSyndrome()), 64'(1));
    streamPacket("flipBit7", TOTAL);
    idleCheck("flip tail", 1);
`endif

    // Header instance: 1 lane, 1 bit/clock, only bit 23 set.
    begin
      logic [7:0] hp;
      logic       e;
      string      nm;
      hp = 8'h83;
      for (int t = 0; t < HTOT; t++) begin
        hStart = (t == 0);
`ifdef BCH_ECC_SYNDROME_EN
        hDataIn = (t < HDC) ? 1'(t == HDC - 1) : hp[t - HDC];
`else
        hDataIn = (t < HDC) ? 1'(t == HDC - 1) : 1'($urandom);
`endif
        start = 1'b0;
        @(posedge clock);
        #1;
        e  = (t < HDC) ? (t == HDC - 1) : hp[t - HDC];
        nm = $sformatf("hdr w%0d", t);
        checkVal({nm, " data"},   64'(hDataOut), 64'(e));
        checkVal({nm, " valid"},  64'(hValid),   64'(1));
        checkVal({nm, " parity"}, 64'(hParity),  64'(t >= HDC));
        checkVal({nm, " last"},   64'(hLast),    64'(t == HTOT - 1));
        checkVal({nm, " busy"},   64'(hBusy),    64'(1));
`ifdef BCH_ECC_SYNDROME_EN
        checkVal({nm, " syndrome"}, 64'(hSynErr), 64'(0));
`endif
      end
      hStart = 1'b0;
      @(posedge clock);
      #1;
      checkVal("hdr idle valid", 64'(hValid), 64'(0));
      checkVal("hdr idle data",  64'(hDataOut), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
